// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the
// SDRAM controller: FSM state encoding, CTI cycle-type codes and default
// bus widths.
package wb_arb_pkg;

    // Default bus geometry and watchdog limit
    localparam int AW_DEF  = 26;
    localparam int DW_DEF  = 32;
    localparam int TMO_DEF = 255;

    // Wishbone registered-feedback cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Arbiter state; the grant register is derived alongside it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // One-hot grant vector belonging to a state (00 when idle)
    function automatic logic [1:0] state_gnt(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == GNT0) g = 2'b01;
        if (s == GNT1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_wdog.sv
// Bus watchdog for wb_arb2. Built only when WB_ARB_TMO_EN is defined.
// Counts granted cycles where the owning master strobes and the slave does
// not acknowledge; when the count reaches LIMIT it raises a one-cycle error
// to the owning master and tells the arbiter to drop the grant.
`ifdef WB_ARB_TMO_EN
module wb_arb_wdog #(
    parameter int LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] gnt,
    input  logic       stb,
    input  logic       ack,
    output logic       hit,
    output logic [1:0] err
);

    logic [7:0] cnt;
    logic [7:0] cnt_base;
    logic [1:0] gnt_seen;
    logic       stall;

    // A grant change restarts the count from zero in the same cycle, so the
    // first stalled cycle of a new owner is counted as cycle 1.
    always_comb begin
        cnt_base = (gnt != gnt_seen) ? 8'd0 : cnt;
        stall    = (gnt != 2'b00) && stb && !ack;
        hit      = stall && (cnt_base == 8'(LIMIT - 1));
        err      = hit ? gnt : 2'b00;
    end

    // Stall counter and previous-grant tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 8'd0;
            gnt_seen <= 2'b00;
        end else begin
            gnt_seen <= gnt;
            if (ack)
                cnt <= 8'd0;
            else if (stall)
                cnt <= cnt_base + 8'd1;
            else
                cnt <= cnt_base;
        end
    end

endmodule
`endif

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller.
// The grant is registered; the slave bus is muxed combinationally from the
// registered grant so a request reaches s_stb_o one cycle after it appears.
// Once granted, a master keeps the bus for as long as its cyc stays high.
// Optional feature: define WB_ARB_TMO_EN to build the stall watchdog
// (wb_arb_wdog) that errors out and releases a master stuck for TMO cycles.
// Handshake: a master requests with cyc & stb; it is served when it owns the
// grant, and a beat completes on the cycle its ack (or err) is high.
module wb_arb2
    import wb_arb_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int SW  = DW / 8,
    parameter int TMO = TMO_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_resetn,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [SW-1:0] m0_sel_i,
    input  logic [2:0]    m0_cti_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [SW-1:0] m1_sel_i,
    input  logic [2:0]    m1_cti_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_addr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [SW-1:0] s_sel_o,
    output logic [2:0]    s_cti_o,
    input  logic          s_ack_i,
    input  logic [DW-1:0] s_dat_i,

    output logic [1:0]    gnt_o
);

    arb_state_t state;
    logic [1:0] gnt_q;
    logic       last_gnt;   // index of the master granted most recently
    logic       req0;
    logic       req1;
    logic       tmo_hit;

`ifdef WB_ARB_TMO_EN
    logic       lock0;
    logic       lock1;
    logic       gnt_stb;
    logic [1:0] wdog_err;

    // A timed-out master may not be regranted until it drops cyc once
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            lock0 <= 1'b0;
            lock1 <= 1'b0;
        end else begin
            if (!m0_cyc_i)
                lock0 <= 1'b0;
            else if (wdog_err[0])
                lock0 <= 1'b1;
            if (!m1_cyc_i)
                lock1 <= 1'b0;
            else if (wdog_err[1])
                lock1 <= 1'b1;
        end
    end

    // Requests seen by the arbiter, masked while a master is locked out
    always_comb begin
        req0    = m0_cyc_i && m0_stb_i && !lock0;
        req1    = m1_cyc_i && m1_stb_i && !lock1;
        gnt_stb = (gnt_q[0] && m0_stb_i) || (gnt_q[1] && m1_stb_i);
    end

    wb_arb_wdog #(
        .LIMIT (TMO)
    ) u_wdog (
        .clk   (wb_clk_i),
        .rst_n (wb_resetn),
        .gnt   (gnt_q),
        .stb   (gnt_stb),
        .ack   (s_ack_i),
        .hit   (tmo_hit),
        .err   (wdog_err)
    );

    assign m0_err_o = wdog_err[0];
    assign m1_err_o = wdog_err[1];
`else
    logic [7:0] unused_tmo;

    // Without the watchdog a request is simply cyc & stb
    always_comb begin
        req0 = m0_cyc_i && m0_stb_i;
        req1 = m1_cyc_i && m1_stb_i;
    end

    assign tmo_hit    = 1'b0;
    assign m0_err_o   = 1'b0;
    assign m1_err_o   = 1'b0;
    assign unused_tmo = 8'(TMO);
`endif

    // Grant FSM: round-robin on ties, hold while cyc is high, hand over
    // directly to a waiting master on release
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state    <= IDLE;
            gnt_q    <= 2'b00;
            last_gnt <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 && (!req1 || last_gnt)) begin
                        state    <= GNT0;
                        gnt_q    <= state_gnt(GNT0);
                        last_gnt <= 1'b0;
                    end else if (req1) begin
                        state    <= GNT1;
                        gnt_q    <= state_gnt(GNT1);
                        last_gnt <= 1'b1;
                    end
                end
                GNT0: begin
                    if (tmo_hit) begin
                        state <= IDLE;
                        gnt_q <= state_gnt(IDLE);
                    end else if (!m0_cyc_i) begin
                        if (req1) begin
                            state    <= GNT1;
                            gnt_q    <= state_gnt(GNT1);
                            last_gnt <= 1'b1;
                        end else begin
                            state <= IDLE;
                            gnt_q <= state_gnt(IDLE);
                        end
                    end
                end
                GNT1: begin
                    if (tmo_hit) begin
                        state <= IDLE;
                        gnt_q <= state_gnt(IDLE);
                    end else if (!m1_cyc_i) begin
                        if (req0) begin
                            state    <= GNT0;
                            gnt_q    <= state_gnt(GNT0);
                            last_gnt <= 1'b0;
                        end else begin
                            state <= IDLE;
                            gnt_q <= state_gnt(IDLE);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= state_gnt(IDLE);
                end
            endcase
        end
    end

    // Slave bus and acks follow the registered grant; idle drives zeros
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = CTI_CLASSIC;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        unique case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_cti_o  = m0_cti_i;
                m0_ack_o = s_ack_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                m1_ack_o = s_ack_i;
            end
            default: ;
        endcase
    end

    // Read data goes to both masters; only the ack says whose it is
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = gnt_q;

endmodule

// File: tb/tb_wb_arb2.sv
// Testbench for wb_arb2: directed scenarios plus a randomized phase, all
// checked against a bus-owner reference model kept in the bench.
module tb_wb_arb2;
    import wb_arb_pkg::*;

    localparam int AW   = 26;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int TMO  = 16;
    localparam int BUSW = 3 + AW + DW + SW + 3;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Master side
    logic          cyc  [2];
    logic          stb  [2];
    logic          we   [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdat [2];
    logic [SW-1:0] sel  [2];
    logic [2:0]    cti  [2];
    logic          ack  [2];
    logic          err  [2];
    logic [DW-1:0] rdat [2];

    // Slave side
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_dat;
    logic [SW-1:0] s_sel;
    logic [2:0]    s_cti;
    logic          s_ack;
    logic [DW-1:0] s_rdat;
    logic [1:0]    gnt;

    wb_arb2 #(.AW(AW), .DW(DW), .SW(SW), .TMO(TMO)) dut (
        .wb_clk_i  (clk),     .wb_resetn (rst_n),
        .m0_cyc_i  (cyc[0]),  .m0_stb_i  (stb[0]),  .m0_we_i (we[0]),
        .m0_addr_i (addr[0]), .m0_dat_i  (wdat[0]), .m0_sel_i (sel[0]),
        .m0_cti_i  (cti[0]),  .m0_ack_o  (ack[0]),  .m0_dat_o (rdat[0]),
        .m0_err_o  (err[0]),
        .m1_cyc_i  (cyc[1]),  .m1_stb_i  (stb[1]),  .m1_we_i (we[1]),
        .m1_addr_i (addr[1]), .m1_dat_i  (wdat[1]), .m1_sel_i (sel[1]),
        .m1_cti_i  (cti[1]),  .m1_ack_o  (ack[1]),  .m1_dat_o (rdat[1]),
        .m1_err_o  (err[1]),
        .s_cyc_o   (s_cyc),   .s_stb_o   (s_stb),   .s_we_o  (s_we),
        .s_addr_o  (s_addr),  .s_dat_o   (s_dat),   .s_sel_o (s_sel),
        .s_cti_o   (s_cti),   .s_ack_i   (s_ack),   .s_dat_i (s_rdat),
        .gnt_o     (gnt)
    );

    // Scoreboard state
    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    // Reference model: who owns the bus (-1 none) and who won last
    int owner = -1;
    int last  = 1;

    // Values sampled mid-cycle by step() for directed checks
    logic [1:0]    seen_gnt;
    logic          seen_stb;
    logic [1:0]    seen_ack;
    logic [DW-1:0] seen_rdat0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BUSW-1:0] obs_bus();
        return {s_cyc, s_stb, s_we, s_addr, s_dat, s_sel, s_cti};
    endfunction

    function automatic logic [BUSW-1:0] exp_bus();
        if (owner < 0) return '0;
        return {cyc[owner], stb[owner], we[owner], addr[owner], wdat[owner], sel[owner], cti[owner]};
    endfunction

    // Ownership rules: a free bus goes to the sole requester, or on a tie to
    // the master that did not win last; an owner keeps the bus until its cyc
    // drops, then it passes straight to a waiting master if there is one.
    task automatic model_step();
        bit r0, r1;
        r0 = cyc[0] && stb[0];
        r1 = cyc[1] && stb[1];
        if (owner < 0) begin
            if (r0 && r1) owner = (last == 0) ? 1 : 0;
            else if (r0)  owner = 0;
            else if (r1)  owner = 1;
            if (owner >= 0) last = owner;
        end else if (!cyc[owner]) begin
            if ((owner == 0) ? r1 : r0) begin
                owner = 1 - owner;
                last  = owner;
            end else begin
                owner = -1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [1:0] eg;
        eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        check("gnt", gnt, eg);
        check("s_bus", obs_bus(), exp_bus());
        check("m0_ack", ack[0], (owner == 0) && s_ack);
        check("m1_ack", ack[1], (owner == 1) && s_ack);
        check("m_dat", {rdat[1], rdat[0]}, {s_rdat, s_rdat});
        check("err", {err[1], err[0]}, 2'b00);
    endtask

    // One bus cycle: called at a negedge with master inputs already set
    task automatic step(input int ack_pct);
        #1;
        s_ack = ($urandom_range(99) < ack_pct);
        if (s_cyc && s_stb && !s_we && mem.exists(s_addr)) s_rdat = mem[s_addr];
        else s_rdat = $urandom;
        #1;
        check_outputs();
        seen_gnt   = gnt;
        seen_stb   = s_stb;
        seen_ack   = {ack[1], ack[0]};
        seen_rdat0 = rdat[0];
        if (s_cyc && s_stb && s_we && s_ack) mem[s_addr] = s_dat;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_masters();
        for (int m = 0; m < 2; m++) begin
            cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0; addr[m] = '0;
            wdat[m] = '0; sel[m] = '0; cti[m] = CTI_CLASSIC;
        end
    endtask

    // Reset with both masters requesting and the slave acking: all zero
    task automatic do_reset();
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin cyc[m] = 1'b1; stb[m] = 1'b1; end
        s_ack  = 1'b1;
        s_rdat = '0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_gnt", gnt, 2'b00);
        check("rst_bus", obs_bus(), '0);
        check("rst_ack", {ack[1], ack[0]}, 2'b00);
        check("rst_err", {err[1], err[0]}, 2'b00);
        @(negedge clk);
        clear_masters();
        s_ack = 1'b0;
        rst_n = 1'b1;
        owner = -1;
        last  = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int run [2];
        int beats;
        bit got;

        clear_masters();
        s_ack = 1'b0;
        s_rdat = '0;
        rst_n = 1'b0;
        @(negedge clk);

        // Single master write then readback
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 26'h0000100;
        wdat[0] = 32'hDEADBEEF; sel[0] = 4'hF; cti[0] = CTI_CLASSIC;
        step(0);
        check("t1_idle_stb", seen_stb, 1'b0);
        step(100);
        check("t1_stb", seen_stb, 1'b1);
        check("t1_gnt", seen_gnt, 2'b01);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        step(0);
        cyc[0] = 1'b1; stb[0] = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            step(100);
            if (seen_ack[0]) begin
                got = 1'b1;
                check("t1_rdat", seen_rdat0, exp_q.pop_front());
            end
        end
        check("t1_rd_ack", got, 1'b1);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        step(0);

        // Tie after reset, seamless hand-over, next tie
        do_reset();
        for (int m = 0; m < 2; m++) begin cyc[m] = 1'b1; stb[m] = 1'b1; end
        step(100);
        check("t2_idle", seen_gnt, 2'b00);
        step(100);
        check("t2_first", seen_gnt, 2'b01);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        step(100);
        step(100);
        check("t2_switch", seen_gnt, 2'b10);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        step(100);
        step(100);
        check("t2_released", seen_gnt, 2'b00);
        for (int m = 0; m < 2; m++) begin cyc[m] = 1'b1; stb[m] = 1'b1; end
        step(100);
        step(100);
        check("t2_tie", seen_gnt, 2'b01);

        // m1 INCR burst while m0 waits
        do_reset();
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; cti[1] = CTI_INCR; sel[1] = 4'hF;
        step(0);
        cyc[0] = 1'b1; stb[0] = 1'b1;
        beats = 0;
        for (int k = 0; k < 20 && beats < 8; k++) begin
            cti[1]  = (beats == 7) ? CTI_EOB : CTI_INCR;
            addr[1] = AW'(32'h200 + beats * 4);
            wdat[1] = $urandom;
            step(100);
            check("t3_gnt", seen_gnt, 2'b10);
            check("t3_m0_ack", seen_ack[0], 1'b0);
            if (seen_ack[1]) beats++;
        end
        check("t3_beats", beats, 8);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        step(100);
        step(100);
        check("t3_handoff", seen_gnt, 2'b01);

        // Reset during beat 3 of an m0 burst
        do_reset();
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; cti[0] = CTI_INCR; sel[0] = 4'hF;
        step(100);
        for (int b = 0; b < 2; b++) begin
            addr[0] = AW'(b * 4);
            step(100);
        end
        addr[0] = AW'(8);
        #2;
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t4_gnt", gnt, 2'b00);
        check("t4_bus", obs_bus(), '0);
        check("t4_ack", {ack[1], ack[0]}, 2'b00);
        check("t4_err", {err[1], err[0]}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        owner = -1;
        last  = 1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        step(100);
        check("t4_idle", seen_gnt, 2'b00);
        step(100);
        check("t4_m1", seen_gnt, 2'b10);

        // Randomized traffic against the model
        do_reset();
        run[0] = 0;
        run[1] = 0;
        for (int n = 0; n < 600; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (run[m] == 0 && $urandom_range(2) == 0) run[m] = $urandom_range(1, 10);
                cyc[m] = (run[m] != 0);
                if (run[m] != 0) run[m]--;
                stb[m]  = ($urandom_range(3) != 0);
                we[m]   = $urandom_range(1);
                addr[m] = AW'($urandom_range(15));
                wdat[m] = $urandom;
                sel[m]  = SW'($urandom);
                case ($urandom_range(2))
                    0:       cti[m] = CTI_CLASSIC;
                    1:       cti[m] = CTI_INCR;
                    default: cti[m] = CTI_EOB;
                endcase
            end
            step(60);
        end

`ifdef WB_ARB_TMO_EN
        // Stalled slave: error at stall cycle TMO, release, lockout
        begin
            int first_err;
            int pulses;
            do_reset();
            cyc[0] = 1'b1; stb[0] = 1'b1;
            s_ack = 1'b0;
            first_err = -1;
            pulses = 0;
            for (int k = 0; k <= 20; k++) begin
                #2;
                if (err[0]) begin
                    pulses++;
                    if (first_err < 0) first_err = k;
                end
                check("tmo_m1_err", err[1], 1'b0);
                if (k > TMO) check("tmo_idle", gnt, 2'b00);
                @(negedge clk);
            end
            check("tmo_cycle", first_err, TMO);
            check("tmo_pulses", pulses, 1);
            cyc[0] = 1'b0; stb[0] = 1'b0;
            @(negedge clk);
            cyc[0] = 1'b1; stb[0] = 1'b1;
            #2;
            check("tmo_relock", gnt, 2'b00);
            @(negedge clk);
            #2;
            check("tmo_regrant", gnt, 2'b01);
            @(negedge clk);
            do_reset();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
